regfile_mp_bypass: RTL and testbench

//  Parametrised multi-port integer register file for the stage-5 decode/read slot.

---
 rtl/regfile_mp_bypass.sv | 82 ++++++++
 tb/tb_regfile_mp_bypass.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_bypass.sv
// Multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.
// Read results and busy flags are registered (latency 1); register 0 always reads zero and is never busy.
module regfile_mp_bypass #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    localparam int TAG_W    = $clog2(NUM_REGS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rd_en,
    input  logic [NUM_READ*TAG_W-1:0] rs,
    output logic [NUM_READ*XLEN-1:0]  rs_read,
    output logic [NUM_READ-1:0]       rs_busy,
    input  logic [NUM_WRITE-1:0]      we,
    input  logic [NUM_WRITE*TAG_W-1:0] wd_tag,
    input  logic [NUM_WRITE*XLEN-1:0] wd_value,
    input  logic                      issue_vld,
    input  logic [TAG_W-1:0]          issue_tag
);

    logic [XLEN-1:0]          regs [NUM_REGS];
    logic [NUM_REGS-1:0]      busy;
    logic [NUM_READ*XLEN-1:0] rd_val_p0;
    logic [NUM_READ-1:0]      rd_busy_p0;

    // Value and busy state of a tag as they will be after this cycle's updates.
    // Later write ports override earlier ones; an issue overrides any write clear.
    function automatic logic [XLEN:0] read_bypass(input logic [TAG_W-1:0] tag);
        logic [XLEN-1:0] val;
        logic            b;
        val = regs[tag];
        b   = busy[tag];
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (we[j] && (wd_tag[j*TAG_W +: TAG_W] == tag)) begin
                val = wd_value[j*XLEN +: XLEN];
                b   = 1'b0;
            end
        end
        if (issue_vld && (issue_tag == tag))
            b = 1'b1;
        if (tag == '0) begin
            val = '0;
            b   = 1'b0;
        end
        return {b, val};
    endfunction

    // Stage p0: bypassed read lookup
    always_comb begin
        rd_val_p0  = '0;
        rd_busy_p0 = '0;
        for (int i = 0; i < NUM_READ; i++)
            {rd_busy_p0[i], rd_val_p0[i*XLEN +: XLEN]} = read_bypass(rs[i*TAG_W +: TAG_W]);
    end

    // Stage p1: architectural state update and registered read outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                regs[k] <= '0;
            busy    <= '0;
            rs_read <= '0;
            rs_busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (we[j] && (wd_tag[j*TAG_W +: TAG_W] != '0)) begin
                    regs[wd_tag[j*TAG_W +: TAG_W]] <= wd_value[j*XLEN +: XLEN];
                    busy[wd_tag[j*TAG_W +: TAG_W]] <= 1'b0;
                end
            end
            if (issue_vld && (issue_tag != '0))
                busy[issue_tag] <= 1'b1;
            if (rd_en) begin
                rs_read <= rd_val_p0;
                rs_busy <= rd_busy_p0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Self-checking bench for regfile_mp_bypass: vector table plus reset sequence, expected
// outputs queued when stimulus is driven and compared one clock later.
module tb_regfile_mp_bypass;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               rd_en = 1'b0;
    logic [2*TAG_W-1:0] rs = '0;
    logic [2*XLEN-1:0]  rs_read;
    logic [1:0]         rs_busy;
    logic [1:0]         we = '0;
    logic [2*TAG_W-1:0] wd_tag = '0;
    logic [2*XLEN-1:0]  wd_value = '0;
    logic               issue_vld = 1'b0;
    logic [TAG_W-1:0]   issue_tag = '0;

    regfile_mp_bypass dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_en    (rd_en),
        .rs       (rs),
        .rs_read  (rs_read),
        .rs_busy  (rs_busy),
        .we       (we),
        .wd_tag   (wd_tag),
        .wd_value (wd_value),
        .issue_vld(issue_vld),
        .issue_tag(issue_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             rd_en;
        logic [TAG_W-1:0] rs0, rs1;
        logic [1:0]       we;
        logic [TAG_W-1:0] t0, t1;
        logic [31:0]      v0, v1;
        logic             iv;
        logic [TAG_W-1:0] it;
        logic [31:0]      e0, e1;
        logic [1:0]       eb;      // {busy port1, busy port0}
    } vec_t;

    typedef struct {
        logic [31:0] d0, d1;
        logic [1:0]  b;
    } exp_t;

    vec_t tbl [14];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clock);
        rd_en     = v.rd_en;
        rs        = {v.rs1, v.rs0};
        we        = v.we;
        wd_tag    = {v.t1, v.t0};
        wd_value  = {v.v1, v.v0};
        issue_vld = v.iv;
        issue_tag = v.it;
        e.d0 = v.e0;
        e.d1 = v.e1;
        e.b  = v.eb;
        sb.push_back(e);
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got 0x%08h expected an entry", nm, rs_read[31:0]);
        end else begin
            e = sb.pop_front();
            cmp({nm, ".rd0"},  rs_read[31:0],  e.d0);
            cmp({nm, ".rd1"},  rs_read[63:32], e.d1);
            cmp({nm, ".busy"}, {30'd0, rs_busy}, {30'd0, e.b});
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        drive(v);
        check_out(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        //          rd rs0 rs1 we  t0  t1  v0            v1            iv it  e0            e1            eb
        tbl[0]  = '{1, 0,  0,  1,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0,  32'h0,        32'h0,        2'b00};
        tbl[1]  = '{1, 5,  5,  0,  0,  0,  32'h0,        32'h0,        0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        tbl[2]  = '{1, 5,  7,  3,  7,  7,  32'h11,       32'h22,       0, 0,  32'hDEADBEEF, 32'h22,       2'b00};
        tbl[3]  = '{1, 7,  0,  0,  0,  0,  32'h0,        32'h0,        0, 0,  32'h22,       32'h0,        2'b00};
        tbl[4]  = '{1, 0,  0,  1,  0,  0,  32'hFFFFFFFF, 32'h0,        1, 0,  32'h0,        32'h0,        2'b00};
        tbl[5]  = '{1, 9,  9,  0,  0,  0,  32'h0,        32'h0,        1, 9,  32'h0,        32'h0,        2'b11};
        tbl[6]  = '{1, 9,  5,  1,  9,  0,  32'h99,       32'h0,        1, 9,  32'h99,       32'hDEADBEEF, 2'b01};
        tbl[7]  = '{1, 9,  9,  2,  0,  9,  32'h0,        32'h9A,       0, 0,  32'h9A,       32'h9A,       2'b00};
        tbl[8]  = '{0, 3,  3,  1,  3,  0,  32'h55,       32'h0,        1, 4,  32'h9A,       32'h9A,       2'b00};
        tbl[9]  = '{1, 3,  4,  0,  0,  0,  32'h0,        32'h0,        0, 0,  32'h55,       32'h0,        2'b10};
        tbl[10] = '{1, 4,  6,  3,  4,  6,  32'h44,       32'h66,       0, 0,  32'h44,       32'h66,       2'b00};
        tbl[11] = '{1, 31, 7,  2,  0,  31, 32'h0,        32'hFFFFFFFF, 1, 31, 32'hFFFFFFFF, 32'h22,       2'b01};
        tbl[12] = '{0, 0,  0,  0,  0,  0,  32'h0,        32'h0,        0, 0,  32'hFFFFFFFF, 32'h22,       2'b01};
        tbl[13] = '{1, 31, 3,  0,  0,  0,  32'h0,        32'h0,        0, 0,  32'hFFFFFFFF, 32'h55,       2'b01};

        // Initial reset state
        #12;
        cmp("por.rd",   rs_read[31:0], 32'h0);
        cmp("por.busy", {30'd0, rs_busy}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-run: outputs clear without a clock edge
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        cmp("arst.rd0",  rs_read[31:0],  32'h0);
        cmp("arst.rd1",  rs_read[63:32], 32'h0);
        cmp("arst.busy", {30'd0, rs_busy}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Previously written / busy registers now read zero and not busy
        run_vec('{1, 5, 7, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00}, "post_rst_a");
        run_vec('{1, 31, 3, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00}, "post_rst_b");
        run_vec('{1, 9, 4, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00}, "post_rst_c");

        // Back-to-back write and dependent read across consecutive cycles
        run_vec('{1, 0, 0, 1, 12, 0, 32'hA5A5A5A5, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00}, "b2b_wr");
        run_vec('{1, 12, 12, 2, 0, 12, 32'h0, 32'h5A5A5A5A, 0, 0, 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b00}, "b2b_byp");
        run_vec('{1, 12, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h5A5A5A5A, 32'h0, 2'b00}, "b2b_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
